// File: rtl/adam_pause_seq_pkg.sv
// Shared ADAM types for the pause/resume sequencer and related watchdog logic.
package adam_pause_seq_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        PAUSING  = 2'd1,
        PAUSED   = 2'd2,
        RESUMING = 2'd3
    } pause_seq_state_t;

endpackage

// File: rtl/adam_sat_counter.sv
// Clearable saturating up-counter; clear has priority over increment.
module adam_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/adam_pause_seq.sv
// Ordered pause/resume sequencer: ascending domain order on pause, descending on resume.
// state    | meaning
// RUN      | idle, no domain requested, pause_ack low
// PAUSING  | raising requests on domain idx, one at a time
// PAUSED   | every unmasked domain acked, pause_ack high
// RESUMING | dropping requests on domain idx-1, one at a time
module adam_pause_seq
    import adam_pause_seq_pkg::*;
#(
    parameter int NO_DOMAINS = 2,
    parameter int TO_WIDTH   = 16,
    parameter int IDX_WIDTH  = $clog2(NO_DOMAINS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause_req,
    output logic                  pause_ack,
    output logic [NO_DOMAINS-1:0] dom_pause_req,
    input  logic [NO_DOMAINS-1:0] dom_pause_ack,
    input  logic [NO_DOMAINS-1:0] dom_mask,
    input  logic [TO_WIDTH-1:0]   to_cycles,
    input  logic                  err_clr,
    output logic                  err,
    output logic [IDX_WIDTH-1:0]  err_idx
);

    pause_seq_state_t      state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  pause_ack_q, pause_ack_d;
    logic [NO_DOMAINS-1:0] dom_pause_req_q, dom_pause_req_d;
    logic                  err_q, err_d;
    logic [IDX_WIDTH-1:0]  err_idx_q, err_idx_d;

    logic [IDX_WIDTH-1:0]  act_idx;
    logic [NO_DOMAINS-1:0] act_sel;
    logic                  act_mask, act_req, act_ack;
    logic                  idx_at_top, idx_zero;
    logic                  waiting, to_hit, cnt_clr;
    logic [TO_WIDTH-1:0]   to_cnt;

    assign idx_at_top = (idx_q == IDX_WIDTH'(NO_DOMAINS));
    assign idx_zero   = (idx_q == '0);
    assign act_idx    = (state_q == RESUMING) ? idx_q - IDX_WIDTH'(1) : idx_q;

    // Out-of-range act_idx (idx==NO_DOMAINS, or idx-1 wrapping) selects nothing.
    always_comb begin
        act_sel  = '0;
        act_mask = 1'b0;
        act_req  = 1'b0;
        act_ack  = 1'b0;
        for (int i = 0; i < NO_DOMAINS; i++) begin
            if (act_idx == IDX_WIDTH'(i)) begin
                act_sel[i] = 1'b1;
                act_mask   = dom_mask[i];
                act_req    = dom_pause_req_q[i];
                act_ack    = dom_pause_ack[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        pause_ack_d     = pause_ack_q;
        dom_pause_req_d = dom_pause_req_q;
        waiting         = 1'b0;
        case (state_q)
            RUN: begin
                if (pause_req) begin
                    state_d = PAUSING;
                    idx_d   = '0;
                end
            end
            PAUSING: begin
                if (!pause_req) begin
                    state_d = RESUMING;
                    idx_d   = idx_q + IDX_WIDTH'(act_req);
                end else if (idx_at_top) begin
                    state_d     = PAUSED;
                    pause_ack_d = 1'b1;
                end else if (act_mask) begin
                    idx_d = idx_q + IDX_WIDTH'(1);
                end else if (!act_req) begin
                    dom_pause_req_d = dom_pause_req_q | act_sel;
                end else if (act_ack) begin
                    idx_d = idx_q + IDX_WIDTH'(1);
                end else begin
                    waiting = 1'b1;
                end
            end
            PAUSED: begin
                if (!pause_req) begin
                    state_d = RESUMING;
                end
            end
            RESUMING: begin
                if (idx_zero) begin
                    state_d     = RUN;
                    pause_ack_d = 1'b0;
                end else if (pause_req) begin
                    state_d = PAUSING;
                    idx_d   = idx_q - IDX_WIDTH'(1);
                end else if (act_mask || (!act_req && !act_ack)) begin
                    idx_d = idx_q - IDX_WIDTH'(1);
                end else if (act_req) begin
                    dom_pause_req_d = dom_pause_req_q & ~act_sel;
                end else begin
                    waiting = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign cnt_clr = (idx_d != idx_q) || (state_d != state_q);

    adam_sat_counter #(.WIDTH(TO_WIDTH)) u_to_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (waiting),
        .cnt (to_cnt)
    );

    // A timeout arriving together with err_clr keeps the flag set.
    assign to_hit = (to_cycles != '0) && (to_cnt == to_cycles) && !err_q
                    && ((state_q == PAUSING) || (state_q == RESUMING));

    always_comb begin
        err_d     = err_q;
        err_idx_d = err_idx_q;
        if (to_hit) begin
            err_d     = 1'b1;
            err_idx_d = act_idx;
        end else if (err_clr) begin
            err_d     = 1'b0;
            err_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            idx_q           <= '0;
            pause_ack_q     <= 1'b0;
            dom_pause_req_q <= '0;
            err_q           <= 1'b0;
            err_idx_q       <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            pause_ack_q     <= pause_ack_d;
            dom_pause_req_q <= dom_pause_req_d;
            err_q           <= err_d;
            err_idx_q       <= err_idx_d;
        end
    end

    assign pause_ack     = pause_ack_q;
    assign dom_pause_req = dom_pause_req_q;
    assign err           = err_q;
    assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_adam_pause_seq.sv
// Scoreboard bench: expected output transitions (cycle, signal, value) are queued by the stimulus side.
module tb_adam_pause_seq;

    localparam int N  = 3;
    localparam int TW = 16;
    localparam int IW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pause_req = 1'b0;
    logic          err_clr = 1'b0;
    logic          pause_ack;
    logic          err;
    logic [IW-1:0] err_idx;
    logic [N-1:0]  dom_pause_req;
    logic [N-1:0]  dom_pause_ack;
    logic [N-1:0]  dom_mask = '0;
    logic [TW-1:0] to_cycles = '0;

    int           dly [N];
    logic [N-1:0] stall = '0;
    logic [7:0]   hist [N];
    int           cyc = 0;

    typedef struct {
        int cyc;
        int kind;   // 0 pause_ack, 1 dom_pause_req[idx], 2 err (idx = err_idx)
        int idx;
        bit val;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;
    bit  err_m = 1'b0;
    bit  mon_en = 1'b0;

    adam_pause_seq #(.NO_DOMAINS(N), .TO_WIDTH(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .pause_req     (pause_req),
        .pause_ack     (pause_ack),
        .dom_pause_req (dom_pause_req),
        .dom_pause_ack (dom_pause_ack),
        .dom_mask      (dom_mask),
        .to_cycles     (to_cycles),
        .err_clr       (err_clr),
        .err           (err),
        .err_idx       (err_idx)
    );

    always #5 clk = ~clk;

    // Domain responders: ack follows req after dly[i] cycles; stall holds ack low.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) hist[i] <= {hist[i][6:0], dom_pause_req[i]};
    end

    always_comb begin
        dom_pause_ack = '0;
        for (int i = 0; i < N; i++) begin
            if (!stall[i]) begin
                dom_pause_ack[i] = (dly[i] == 0) ? dom_pause_req[i] : hist[i][3'(dly[i] - 1)];
            end
        end
    end

    function automatic void push(int c, int k, int i, bit v);
        ev_t e;
        e.cyc = c; e.kind = k; e.idx = i; e.val = v;
        q.push_back(e);
    endfunction

    function automatic void check_ev(int k, int i, bit v);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change: kind=%0d idx=%0d val=%0d at cycle %0d, none expected", k, i, v, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.idx != i || e.val != v || e.cyc != cyc) begin
                fails++;
                $display("FAIL event: got kind=%0d idx=%0d val=%0d cycle=%0d, expected kind=%0d idx=%0d val=%0d cycle=%0d",
                         k, i, v, cyc, e.kind, e.idx, e.val, e.cyc);
            end
        end
    endfunction

    logic         pa_p, err_p;
    logic [N-1:0] req_p;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pause_ack != pa_p) check_ev(0, 0, pause_ack);
            for (int i = 0; i < N; i++)
                if (dom_pause_req[i] != req_p[i]) check_ev(1, i, dom_pause_req[i]);
            if (err != err_p) check_ev(2, int'(err_idx), err);
        end
        pa_p  = pause_ack;
        req_p = dom_pause_req;
        err_p = err;
    end

    // Expected pause walk starting after edge t with domain `first` next to act.
    function automatic void gen_pause(int t, int first);
        for (int i = first; i < N; i++) begin
            if (dom_mask[i]) begin
                t += 1;
            end else begin
                push(t + 1, 1, i, 1'b1);
                if (to_cycles != '0 && !err_m && dly[i] >= int'(to_cycles)) begin
                    push(t + int'(to_cycles) + 2, 2, i, 1'b1);
                    err_m = 1'b1;
                end
                t += dly[i] + 2;
            end
        end
        push(t + 1, 0, 0, 1'b1);
    endfunction

    function automatic void gen_resume(int t, int first);
        for (int i = first; i >= 0; i--) begin
            if (dom_mask[i]) begin
                t += 1;
            end else begin
                push(t + 1, 1, i, 1'b0);
                if (to_cycles != '0 && !err_m && dly[i] >= int'(to_cycles)) begin
                    push(t + int'(to_cycles) + 2, 2, i, 1'b1);
                    err_m = 1'b1;
                end
                t += dly[i] + 2;
            end
        end
        push(t + 1, 0, 0, 1'b0);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected events still pending at cycle %0d, required 0", q.size(), cyc);
            q.delete();
        end
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_err();
        int s;
        if (err_m) begin
            s = cyc;
            err_clr = 1'b1;
            push(s + 1, 2, 0, 1'b0);
            tick();
            err_clr = 1'b0;
            err_m = 1'b0;
            wait_drain(5);
        end
    endtask

    task automatic episode(logic [N-1:0] m, int to);
        int s;
        dom_mask  = m;
        to_cycles = TW'(to);
        s = cyc;
        pause_req = 1'b1;
        gen_pause(s + 1, 0);
        wait_drain(100);
        s = cyc;
        pause_req = 1'b0;
        gen_resume(s + 1, N - 1);
        wait_drain(100);
        clear_err();
        repeat (4) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        for (int i = 0; i < N; i++) begin
            dly[i]  = 0;
            hist[i] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_pause_ack", 32'(pause_ack), 0);
        check("rst_dom_req", 32'(dom_pause_req), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_idx", 32'(err_idx), 0);
        check("rst_to_cnt", 32'(dut.to_cnt), 0);
        mon_en = 1'b1;

        // basic ordered cycle and a masked domain
        episode(3'b000, 0);
        episode(3'b010, 0);
        episode(3'b111, 0);

        // abort while domain 1 is requested but not yet acked
        dly = '{0, 3, 0};
        dom_mask = '0;
        to_cycles = '0;
        s = cyc;
        pause_req = 1'b1;
        push(s + 2, 1, 0, 1'b1);
        push(s + 4, 1, 1, 1'b1);
        push(s + 7, 1, 1, 1'b0);
        push(s + 12, 1, 0, 1'b0);
        wait_cyc(s + 5);
        pause_req = 1'b0;
        wait_drain(30);
        repeat (6) tick();
        check("abort_pause_ack", 32'(pause_ack), 0);
        check("abort_dom_req", 32'(dom_pause_req), 0);

        // timeout on a stalled domain 0, later ack completes the pause
        dly = '{0, 0, 0};
        to_cycles = TW'(10);
        stall = 3'b001;
        s = cyc;
        pause_req = 1'b1;
        push(s + 2, 1, 0, 1'b1);
        push(s + 13, 2, 0, 1'b1);
        err_m = 1'b1;
        wait_cyc(s + 30);
        check("to_still_waiting", 32'(dom_pause_req), 32'h1);
        check("to_err", 32'(err), 1);
        check("to_err_idx", 32'(err_idx), 0);
        stall = '0;
        gen_pause(cyc + 1, 1);
        wait_drain(50);
        clear_err();
        s = cyc;
        pause_req = 1'b0;
        gen_resume(s + 1, N - 1);
        wait_drain(50);
        repeat (4) tick();

        // timeout coinciding with a held err_clr still sets err for one cycle
        err_clr = 1'b1;
        stall = 3'b001;
        s = cyc;
        pause_req = 1'b1;
        push(s + 2, 1, 0, 1'b1);
        push(s + 13, 2, 0, 1'b1);
        push(s + 14, 2, 0, 1'b0);
        wait_cyc(s + 20);
        stall = '0;
        err_clr = 1'b0;
        gen_pause(cyc + 1, 1);
        wait_drain(50);
        s = cyc;
        pause_req = 1'b0;
        gen_resume(s + 1, N - 1);
        wait_drain(50);
        repeat (4) tick();

        // reset mid-resume with idx at 2
        to_cycles = '0;
        s = cyc;
        pause_req = 1'b1;
        gen_pause(s + 1, 0);
        wait_drain(50);
        s = cyc;
        pause_req = 1'b0;
        push(s + 2, 1, 2, 1'b0);
        wait_cyc(s + 3);
        rst = 1'b1;
        push(s + 4, 0, 0, 1'b0);
        push(s + 4, 1, 0, 1'b0);
        push(s + 4, 1, 1, 1'b0);
        tick();
        rst = 1'b0;
        check("mid_rst_dom_req", 32'(dom_pause_req), 0);
        check("mid_rst_pause_ack", 32'(pause_ack), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_to_cnt", 32'(dut.to_cnt), 0);
        wait_drain(5);
        repeat (4) tick();

        // timeout disabled on a long stall: counter saturates, no err
        to_cycles = '0;
        stall = 3'b001;
        s = cyc;
        pause_req = 1'b1;
        push(s + 2, 1, 0, 1'b1);
        wait_cyc(s + 70002);
        check("sat_to_cnt", 32'(dut.to_cnt), 32'h0000_FFFF);
        check("sat_no_err", 32'(err), 0);
        stall = '0;
        gen_pause(cyc + 1, 1);
        wait_drain(50);
        s = cyc;
        pause_req = 1'b0;
        gen_resume(s + 1, N - 1);
        wait_drain(50);
        repeat (4) tick();

        // randomized masks, ack delays and timeout thresholds
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(3, 0));
            episode(3'($urandom), int'($urandom_range(4, 0)));
        end

        check("end_queue_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
